ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Control sequencer for the 8-bit prototype CPU, placed directly downstream of the instruction decoder. It steps each instruction through fetch, decode and execute states. It enables the decoder for one cycle and latches its one-hot instruction lines. It then drives the datapath strobes (PC, IR, RAM, register file, ALU, flags, I/O) and resolves conditional jumps from the C/Z flags.

## Interface
Parameters:
- `AUTO_START`, default 0: when 1, leave IDLE on the cycle after reset release without waiting for RUN.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `RUN`  in  1  start request, sampled in IDLE only.
- `C`, `Z`  in  1 each  carry and zero flags from the flag register.
- `MOVA MOVB MOVC ADD SUB AND NOT RSR RSL JMP JZ JC IN OUT NOP HALT`  in  1 each  one-hot decoder outputs.
- `DEC_EN`  out  1  decoder enable.
- `IR_LD`, `PC_INC`, `PC_LD`  out  1 each  IR load, PC increment, PC load.
- `RAM_RD`, `RAM_WR`  out  1 each  memory read and write strobes.
- `REG_WE`  out  1  register-file write enable.
- `WB_SEL`  out  2  write-back source: 0 = ALU, 1 = RAM, 2 = IN port.
- `ALU_S`  out  3  ALU op: ADD 0, SUB 1, AND 2, NOT 3, RSR 4, RSL 5, PASS 6.
- `FLAG_LD`  out  1  load C/Z from the ALU.
- `OUT_LD`  out  1  load the output port.
- `HALTED`  out  1  high in HLT.
- `STATE`  out  3  current state, for debug.

## Operation
- States and encodings: IDLE 0, F1 1, DEC 2, EX 3, JA 4, HLT 5. Codes 6–7 are illegal and go to IDLE on the next edge.
- IDLE: all strobes 0. Go to F1 when `RUN`=1 or `AUTO_START`=1.
- F1: `RAM_RD`=1, `IR_LD`=1, `PC_INC`=1. Go to DEC.
- DEC: `DEC_EN`=1.
  - Latch the 16 decoder lines into a 16-bit op register.
  - If more than one line is high, keep the lowest-listed one (port order).
  - If none are high, the instruction executes as NOP.
  - Go to EX.
- EX: outputs are a function of the op register only (`DEC_EN`=0).
  - MOVA: `ALU_S`=PASS, `WB_SEL`=0, `REG_WE`=1.
  - MOVB: `ALU_S`=PASS, `RAM_WR`=1.
  - MOVC: `RAM_RD`=1, `WB_SEL`=1, `REG_WE`=1.
  - ADD, SUB, AND, NOT, RSR, RSL: matching `ALU_S`, `WB_SEL`=0, `REG_WE`=1, `FLAG_LD`=1.
  - IN: `WB_SEL`=2, `REG_WE`=1.
  - OUT: `OUT_LD`=1.
  - NOP: no strobes.
  - JMP, JZ, JC: no strobes. Register TAKEN = JMP | (JZ & Z) | (JC & C), with C and Z sampled at the EX edge. Go to JA.
  - HALT: go to HLT.
  - All others: go to F1.
- JA: the address byte sits at PC.
  - If TAKEN: `RAM_RD`=1, `PC_LD`=1.
  - If not TAKEN: `PC_INC`=1 to skip the address byte.
  - Go to F1.
- HLT: `HALTED`=1, all strobes 0. Only reset leaves HLT; `RUN` is ignored.
- Outputs are Moore-style, decoded from the state, the op register and TAKEN. No combinational path runs from any input to any output.
- Outputs not listed for a state are 0. `ALU_S` and `WB_SEL` default to 0.

## Timing
- Reset:
  - Asserting `RST_N` low immediately forces IDLE, op register = 0 and TAKEN = 0.
  - All outputs are 0 and `STATE`=0 while in reset.
  - Reset mid-instruction abandons it; no strobe is issued after the asserting edge.
- Latency per instruction, F1 to the next F1:
  - 3 cycles for non-jump instructions.
  - 4 cycles for JMP, JZ and JC, whether or not the jump is taken.
- With `AUTO_START`=0, F1 is entered on the first edge at which `RUN`=1 in IDLE.
- Flags written by an ALU op in EX (`FLAG_LD`) are visible to a following JZ/JC, because that instruction samples them at its own EX, at least 3 cycles later.
- Simultaneous strobes occur only as listed above. `RAM_RD` and `RAM_WR` are never high together.

## Structure
- Shared package `cpu_pkg`: state encodings, `ALU_S` codes, `WB_SEL` codes, and the op-register bit indices.
- Optional combinational sub-module `ctrl_outdec`: maps {state, op register, TAKEN} to the strobe vector. The FSM, op register and TAKEN stay in `ctrl_seq`.

## Test plan
- Reset in EX during ADD, then release with `RUN`=1 → all outputs 0 during reset; F1 is the first state after release.
- ADD → `STATE` 1,2,3,1. EX shows `ALU_S`=0, `REG_WE`=1, `FLAG_LD`=1, `WB_SEL`=0. `DEC_EN` is high in DEC only.
- JZ with Z=1, then JZ with Z=0 → taken case: JA has `RAM_RD`=1, `PC_LD`=1. Not-taken case: JA has `PC_INC`=1 and `PC_LD`=0. Both take 4 cycles.
- MOVB, then MOVC → MOVB EX: `RAM_WR`=1, `REG_WE`=0. MOVC EX: `RAM_RD`=1, `WB_SEL`=1, `REG_WE`=1.
- HALT, then `RUN` toggled for 10 cycles → `STATE`=5 and `HALTED`=1 held throughout; only `RST_N` low returns to IDLE.
- All decoder lines 0 in DEC, then IN with ADD forced high too → the first instruction behaves as NOP (3 cycles, no strobes). For the second, EX applies only ADD's strobes (`ALU_S`=0, `WB_SEL`=0, `REG_WE`=1, `FLAG_LD`=1), because ADD precedes IN in port order.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, ALU, write-back and op-register encodings for the 8-bit CPU control path
package cpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_DEC  = 3'd2,
    S_EX   = 3'd3,
    S_JA   = 3'd4,
    S_HLT  = 3'd5
  } state_t;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_NOT  = 3'd3;
  localparam logic [2:0] ALU_RSR  = 3'd4;
  localparam logic [2:0] ALU_RSL  = 3'd5;
  localparam logic [2:0] ALU_PASS = 3'd6;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_RAM = 2'd1;
  localparam logic [1:0] WB_IN  = 2'd2;
  localparam int OP_MOVA = 0;
  localparam int OP_MOVB = 1;
  localparam int OP_MOVC = 2;
  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_NOT  = 6;
  localparam int OP_RSR  = 7;
  localparam int OP_RSL  = 8;
  localparam int OP_JMP  = 9;
  localparam int OP_JZ   = 10;
  localparam int OP_JC   = 11;
  localparam int OP_IN   = 12;
  localparam int OP_OUT  = 13;
  localparam int OP_NOP  = 14;
  localparam int OP_HALT = 15;
  function automatic logic [15:0] first_one(input logic [15:0] v);
    return v & (~v + 16'd1);
  endfunction
endpackage

// File: rtl/ctrl_seq.sv
// ctrl_seq: fetch/decode/execute sequencer; CLK/RST_N/RUN/C/Z and 16 one-hot decoder lines in, datapath strobes, HALTED and debug STATE out
module ctrl_seq
  import cpu_pkg::*;
#(
  parameter logic AUTO_START = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RUN,
  input  logic       C,
  input  logic       Z,
  input  logic       MOVA,
  input  logic       MOVB,
  input  logic       MOVC,
  input  logic       ADD,
  input  logic       SUB,
  input  logic       AND,
  input  logic       NOT,
  input  logic       RSR,
  input  logic       RSL,
  input  logic       JMP,
  input  logic       JZ,
  input  logic       JC,
  input  logic       IN,
  input  logic       OUT,
  input  logic       NOP,
  input  logic       HALT,
  output logic       DEC_EN,
  output logic       IR_LD,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic       RAM_RD,
  output logic       RAM_WR,
  output logic       REG_WE,
  output logic [1:0] WB_SEL,
  output logic [2:0] ALU_S,
  output logic       FLAG_LD,
  output logic       OUT_LD,
  output logic       HALTED,
  output logic [2:0] STATE
);
  state_t state;
  logic [15:0] op;
  logic taken;
  logic [15:0] lines;
  logic f1, ex, ja, alu_grp, is_jmp;
  assign lines = {HALT, NOP, OUT, IN, JC, JZ, JMP, RSL, RSR, NOT, AND, SUB, ADD, MOVC, MOVB, MOVA};
  assign is_jmp = op[OP_JMP] | op[OP_JZ] | op[OP_JC];
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      op <= '0;
      taken <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= (RUN || AUTO_START) ? S_F1 : S_IDLE;
        S_F1:   state <= S_DEC;
        S_DEC: begin
          op <= first_one(lines);
          state <= S_EX;
        end
        S_EX: begin
          if (is_jmp) taken <= op[OP_JMP] | (op[OP_JZ] & Z) | (op[OP_JC] & C);
          state <= op[OP_NOP] ? S_F1 : is_jmp ? S_JA : op[OP_HALT] ? S_HLT : S_F1;
        end
        S_JA:   state <= S_F1;
        S_HLT:  state <= S_HLT;
        default: state <= S_IDLE;
      endcase
    end
  end
  assign f1 = state == S_F1;
  assign ex = state == S_EX;
  assign ja = state == S_JA;
  assign alu_grp = |op[OP_RSL:OP_ADD];
  assign STATE = state;
  assign DEC_EN = state == S_DEC;
  assign IR_LD = f1;
  assign PC_INC = f1 | (ja & ~taken);
  assign PC_LD = ja & taken;
  assign RAM_RD = f1 | (ex & op[OP_MOVC]) | (ja & taken);
  assign RAM_WR = ex & op[OP_MOVB];
  assign REG_WE = ex & (op[OP_MOVA] | op[OP_MOVC] | alu_grp | op[OP_IN]);
  assign WB_SEL = !ex ? WB_ALU : op[OP_MOVC] ? WB_RAM : op[OP_IN] ? WB_IN : WB_ALU;
  assign ALU_S = !ex ? ALU_ADD
               : (op[OP_MOVA] | op[OP_MOVB]) ? ALU_PASS
               : op[OP_SUB] ? ALU_SUB
               : op[OP_AND] ? ALU_AND
               : op[OP_NOT] ? ALU_NOT
               : op[OP_RSR] ? ALU_RSR
               : op[OP_RSL] ? ALU_RSL
               : ALU_ADD;
  assign FLAG_LD = ex & alu_grp;
  assign OUT_LD = ex & op[OP_OUT];
  assign HALTED = state == S_HLT;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed self-checking bench for ctrl_seq
module tb_ctrl_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic c = 1'b0;
  logic z = 1'b0;
  logic [15:0] lines = '0;
  logic dec_en, ir_ld, pc_inc, pc_ld, ram_rd, ram_wr, reg_we, flag_ld, out_ld, halted;
  logic [1:0] wb_sel;
  logic [2:0] alu_s, state;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ctrl_seq #(.AUTO_START(1'b0)) dut (
    .CLK(clk), .RST_N(rst_n), .RUN(run), .C(c), .Z(z),
    .MOVA(lines[0]), .MOVB(lines[1]), .MOVC(lines[2]), .ADD(lines[3]),
    .SUB(lines[4]), .AND(lines[5]), .NOT(lines[6]), .RSR(lines[7]),
    .RSL(lines[8]), .JMP(lines[9]), .JZ(lines[10]), .JC(lines[11]),
    .IN(lines[12]), .OUT(lines[13]), .NOP(lines[14]), .HALT(lines[15]),
    .DEC_EN(dec_en), .IR_LD(ir_ld), .PC_INC(pc_inc), .PC_LD(pc_ld),
    .RAM_RD(ram_rd), .RAM_WR(ram_wr), .REG_WE(reg_we), .WB_SEL(wb_sel),
    .ALU_S(alu_s), .FLAG_LD(flag_ld), .OUT_LD(out_ld), .HALTED(halted),
    .STATE(state)
  );
  function automatic logic [14:0] sv(input logic d, ir, pi, pl, rd, wr, we, input logic [1:0] wb,
                                     input logic [2:0] alu, input logic fl, ol, h);
    return {d, ir, pi, pl, rd, wr, we, wb, alu, fl, ol, h};
  endfunction
  localparam logic [14:0] V0    = '0;
  localparam logic [14:0] VF1   = sv(0, 1, 1, 0, 1, 0, 0, 2'd0, 3'd0, 0, 0, 0);
  localparam logic [14:0] VDEC  = sv(1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0);
  localparam logic [14:0] VADD  = sv(0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd0, 1, 0, 0);
  localparam logic [14:0] VSUB  = sv(0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd1, 1, 0, 0);
  localparam logic [14:0] VJAT  = sv(0, 0, 0, 1, 1, 0, 0, 2'd0, 3'd0, 0, 0, 0);
  localparam logic [14:0] VJAN  = sv(0, 0, 1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0);
  localparam logic [14:0] VMOVB = sv(0, 0, 0, 0, 0, 1, 0, 2'd0, 3'd6, 0, 0, 0);
  localparam logic [14:0] VMOVC = sv(0, 0, 0, 0, 1, 0, 1, 2'd1, 3'd0, 0, 0, 0);
  localparam logic [14:0] VIN   = sv(0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 0, 0, 0);
  localparam logic [14:0] VOUT  = sv(0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 1, 0);
  localparam logic [14:0] VHLT  = sv(0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 1);
  logic [14:0] outs;
  assign outs = {dec_en, ir_ld, pc_inc, pc_ld, ram_rd, ram_wr, reg_we, wb_sel, alu_s, flag_ld, out_ld, halted};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [14:0] v);
    check({tag, " state"}, 32'(state), 32'(st));
    check({tag, " outs"}, 32'(outs), 32'(v));
  endtask
  // starts with DUT in F1; leaves it in the F1 that follows the instruction
  task automatic instr(input string tag, input logic [15:0] l, input logic [14:0] vex);
    lines = l;
    tick();
    expect_cycle({tag, " dec"}, 3'd2, VDEC);
    tick();
    expect_cycle({tag, " ex"}, 3'd3, vex);
    lines = '0;
    tick();
    expect_cycle({tag, " next"}, 3'd1, VF1);
  endtask
  task automatic jump(input string tag, input logic [15:0] l, input logic cc, input logic zz, input logic [14:0] vja);
    lines = l;
    c = cc;
    z = zz;
    tick();
    expect_cycle({tag, " dec"}, 3'd2, VDEC);
    tick();
    expect_cycle({tag, " ex"}, 3'd3, V0);
    lines = '0;
    tick();
    c = ~cc;
    z = ~zz;
    expect_cycle({tag, " ja"}, 3'd4, vja);
    tick();
    expect_cycle({tag, " next"}, 3'd1, VF1);
  endtask
  initial begin
    tick();
    tick();
    expect_cycle("reset", 3'd0, V0);
    rst_n = 1'b1;
    tick();
    expect_cycle("idle wait", 3'd0, V0);
    run = 1'b1;
    tick();
    expect_cycle("first f1", 3'd1, VF1);
    run = 1'b0;
    instr("add", 16'h0008, VADD);
    lines = 16'h0008;
    tick();
    tick();
    expect_cycle("add ex pre-reset", 3'd3, VADD);
    rst_n = 1'b0;
    #1;
    expect_cycle("reset in ex", 3'd0, V0);
    run = 1'b1;
    tick();
    expect_cycle("held reset", 3'd0, V0);
    rst_n = 1'b1;
    lines = '0;
    tick();
    expect_cycle("f1 after reset", 3'd1, VF1);
    run = 1'b0;
    jump("jz taken", 16'h0400, 1'b0, 1'b1, VJAT);
    jump("jz not taken", 16'h0400, 1'b1, 1'b0, VJAN);
    jump("jc taken", 16'h0800, 1'b1, 1'b0, VJAT);
    jump("jmp", 16'h0200, 1'b0, 1'b0, VJAT);
    instr("movb", 16'h0002, VMOVB);
    instr("movc", 16'h0004, VMOVC);
    instr("sub", 16'h0010, VSUB);
    instr("out", 16'h2000, VOUT);
    instr("none", 16'h0000, V0);
    instr("in+add", 16'h1008, VADD);
    instr("in", 16'h1000, VIN);
    lines = 16'h8000;
    tick();
    expect_cycle("halt dec", 3'd2, VDEC);
    tick();
    expect_cycle("halt ex", 3'd3, V0);
    lines = '0;
    tick();
    expect_cycle("hlt", 3'd5, VHLT);
    for (int i = 0; i < 10; i++) begin
      run = ~run;
      tick();
      expect_cycle("hlt run", 3'd5, VHLT);
    end
    rst_n = 1'b0;
    #1;
    expect_cycle("hlt reset", 3'd0, V0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
